// File: rtl/div_pkg.sv
// Shared definitions for the iterative single-precision divider: state encoding,
// exponent constants and IEEE-754 field positions.
package div_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam int QBITS    = 26;
   localparam int EXP_W    = 10;
   localparam int CNT_W    = 5;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UNPACK = 2'd1,
      S_DIVIDE = 2'd2,
      S_ROUND  = 2'd3
   } state_t;

endpackage

// File: rtl/div_core_seq_if.sv
// Request/result bundle between the divider core and its requester.
interface div_core_seq_if;

   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] A_q;
   logic [31:0] B_q;
   logic [31:0] temp_result;

   modport master (
      output start, A, B,
      input  busy, done, A_q, B_q, temp_result
   );

   modport slave (
      input  start, A, B,
      output busy, done, A_q, B_q, temp_result
   );

endinterface

// File: rtl/div_norm_round.sv
// Combinational normalise, round-to-nearest-even and overflow/flush-to-zero packer
// for the raw restoring quotient.
module div_norm_round
   import div_pkg::*;
(
   input  logic [QBITS-1:0]        i_q,
   input  logic                    i_rem_nz,
   input  logic signed [EXP_W-1:0] i_exp,
   input  logic                    i_sign,
   output logic [31:0]             o_result
);

   logic [23:0]             w_m;
   logic                    w_g;
   logic                    w_s;
   logic                    w_inc;
   logic [24:0]             w_m_rnd;
   logic [MAN_MSB:0]        w_man;
   logic signed [EXP_W-1:0] w_exp_norm;
   logic signed [EXP_W-1:0] w_exp_fin;

   always_comb begin
      w_m        = '0;
      w_g        = 1'b0;
      w_s        = 1'b0;
      w_exp_norm = i_exp;
      // quotient lies in [0.5, 2): bit 25 tells whether a one-place shift is needed
      if (i_q[QBITS-1]) begin
         w_m = i_q[QBITS-1:2];
         w_g = i_q[1];
         w_s = i_q[0] | i_rem_nz;
      end else begin
         w_m        = i_q[QBITS-2:1];
         w_g        = i_q[0];
         w_s        = i_rem_nz;
         w_exp_norm = i_exp - 10'sd1;
      end

      w_inc   = w_g & (w_s | w_m[0]);
      w_m_rnd = {1'b0, w_m} + {24'd0, w_inc};

      if (w_m_rnd[24]) begin
         w_man     = '0;
         w_exp_fin = w_exp_norm + 10'sd1;
      end else begin
         w_man     = w_m_rnd[MAN_MSB:0];
         w_exp_fin = w_exp_norm;
      end

      if (w_exp_fin >= $signed(10'(EXP_MAX))) begin
         o_result = {i_sign, 8'hFF, 23'h0};
      end else if (w_exp_fin <= 10'sd0) begin
         o_result = {i_sign, 31'h0};
      end else begin
         o_result = {i_sign, w_exp_fin[7:0], w_man};
      end
   end

endmodule

// File: rtl/div_core_seq.sv
// Iterative single-precision divider: one restoring quotient bit per clock, one
// division in flight, normal operands only (special cases are overridden downstream).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start; captures A/B on accept
//   S_UNPACK | builds mantissas, biased exponent difference and sign
//   S_DIVIDE | QBITS restoring iterations, one quotient bit per clock
//   S_ROUND  | normalise/round/pack, writes temp_result and pulses done
module div_core_seq
   import div_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   div_core_seq_if.slave bus
);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [23:0]             r_mb;
   logic [24:0]             r_rem;
   logic [QBITS-1:0]        r_q;
   logic signed [EXP_W-1:0] r_exp;
   logic                    r_sign;
   logic                    r_busy;
   logic                    r_done;
   logic [31:0]             r_a_q;
   logic [31:0]             r_b_q;
   logic [31:0]             r_result;

   logic                    w_ge;
   logic [24:0]             w_diff;
   logic signed [EXP_W-1:0] w_exp_unpack;
   logic [31:0]             w_packed;

   assign w_ge   = (r_rem >= {1'b0, r_mb});
   assign w_diff = r_rem - {1'b0, r_mb};

   assign w_exp_unpack = $signed({2'b00, r_a_q[EXP_MSB:EXP_LSB]})
                       - $signed({2'b00, r_b_q[EXP_MSB:EXP_LSB]})
                       + $signed(10'(EXP_BIAS));

   div_norm_round u_norm_round (
      .i_q      (r_q),
      .i_rem_nz (r_rem != 25'd0),
      .i_exp    (r_exp),
      .i_sign   (r_sign),
      .o_result (w_packed)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mb     <= '0;
         r_rem    <= '0;
         r_q      <= '0;
         r_exp    <= '0;
         r_sign   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_a_q    <= '0;
         r_b_q    <= '0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a_q   <= bus.A;
                  r_b_q   <= bus.B;
                  r_busy  <= 1'b1;
                  r_state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               r_mb    <= {1'b1, r_b_q[MAN_MSB:0]};
               r_rem   <= {2'b01, r_a_q[MAN_MSB:0]};
               r_exp   <= w_exp_unpack;
               r_sign  <= r_a_q[SIGN_BIT] ^ r_b_q[SIGN_BIT];
               r_q     <= '0;
               r_cnt   <= '0;
               r_state <= S_DIVIDE;
            end
            S_DIVIDE: begin
               if (w_ge) begin
                  r_q   <= {r_q[QBITS-2:0], 1'b1};
                  r_rem <= {w_diff[23:0], 1'b0};
               end else begin
                  r_q   <= {r_q[QBITS-2:0], 1'b0};
                  r_rem <= {r_rem[23:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(QBITS - 1)) begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_result <= w_packed;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.A_q         = r_a_q;
   assign bus.B_q         = r_b_q;
   assign bus.temp_result = r_result;

endmodule

// File: tb/tb_div_core_seq.sv
// Directed bench for the iterative divider: reset, latency, rounding/range vectors,
// start-while-busy, back-to-back accept and mid-operation reset.
module tb_div_core_seq;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   div_core_seq_if u_if ();

   div_core_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands so they are sampled on the next rising edge, then drop start.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      u_if.A     = a;
      u_if.B     = b;
      u_if.start = 1'b1;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
   endtask

   // Edges counted from the accepting edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (u_if.done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      u_if.start = 1'b0;
      u_if.A     = '0;
      u_if.B     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_tests++;
      if ({u_if.busy, u_if.done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_flags got busy/done=%b%b want 00", u_if.busy, u_if.done);
      end
      n_tests++;
      if ({u_if.A_q, u_if.B_q, u_if.temp_result} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_regs got A_q=%h B_q=%h res=%h want zeros",
                  u_if.A_q, u_if.B_q, u_if.temp_result);
      end
   endtask

   task automatic test_basic();
      int lat;
      start_op(32'h40C00000, 32'h40000000);
      n_tests++;
      if (u_if.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy got %b want 1", u_if.busy);
      end
      wait_done(lat);
      n_tests++;
      if (lat !== 28) begin
         n_fail++;
         $display("FAIL basic_latency got %0d want 28", lat);
      end
      n_tests++;
      if (u_if.temp_result !== 32'h40400000) begin
         n_fail++;
         $display("FAIL basic_result got %h want 40400000", u_if.temp_result);
      end
      n_tests++;
      if (u_if.A_q !== 32'h40C00000 || u_if.B_q !== 32'h40000000) begin
         n_fail++;
         $display("FAIL basic_echo got A_q=%h B_q=%h want 40C00000 40000000", u_if.A_q, u_if.B_q);
      end
      n_tests++;
      if (u_if.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy_in_done got %b want 0", u_if.busy);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (u_if.done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_width got %b want 0", u_if.done);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] va [11];
      logic [31:0] vb [11];
      logic [31:0] vr [11];
      int lat;
      va[0]  = 32'h3F800000; vb[0]  = 32'h40400000; vr[0]  = 32'h3EAAAAAB; // 1/3
      va[1]  = 32'hBF800000; vb[1]  = 32'h40000000; vr[1]  = 32'hBF000000; // -1/2
      va[2]  = 32'h3F800000; vb[2]  = 32'h3FC00000; vr[2]  = 32'h3F2AAAAB; // 1/1.5
      va[3]  = 32'h7F000000; vb[3]  = 32'h00800000; vr[3]  = 32'h7F800000; // overflow
      va[4]  = 32'h00800000; vb[4]  = 32'h7F000000; vr[4]  = 32'h00000000; // underflow
      va[5]  = 32'h40400000; vb[5]  = 32'h40400000; vr[5]  = 32'h3F800000; // 3/3
      va[6]  = 32'h01000000; vb[6]  = 32'h40000000; vr[6]  = 32'h00800000; // smallest normal
      va[7]  = 32'h00800000; vb[7]  = 32'h40000000; vr[7]  = 32'h00000000; // e==0 flush
      va[8]  = 32'h7F000000; vb[8]  = 32'h3F000000; vr[8]  = 32'h7F800000; // e==255
      va[9]  = 32'h7F7FFFFF; vb[9]  = 32'h3F800000; vr[9]  = 32'h7F7FFFFF; // max finite
      va[10] = 32'hC0C00000; vb[10] = 32'hC0000000; vr[10] = 32'h40400000; // neg/neg
      for (int i = 0; i < 11; i++) begin
         start_op(va[i], vb[i]);
         wait_done(lat);
         n_tests++;
         if (lat !== 28 || u_if.temp_result !== vr[i]) begin
            n_fail++;
            $display("FAIL vec%0d A=%h B=%h got res=%h lat=%0d want res=%h lat=28",
                     i, va[i], vb[i], u_if.temp_result, lat, vr[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int dones;
      int first;
      int lat;
      dones = 0;
      first = -1;
      start_op(32'h40C00000, 32'h40000000);
      for (int n = 1; n <= 28; n++) begin
         if (n == 5 || n == 27) begin
            u_if.A     = 32'h3F800000;
            u_if.B     = 32'h40400000;
            u_if.start = 1'b1;
         end
         @(posedge clk);
         #1;
         u_if.start = 1'b0;
         if (n == 5) begin
            n_tests++;
            if (u_if.A_q !== 32'h40C00000 || u_if.B_q !== 32'h40000000) begin
               n_fail++;
               $display("FAIL busy_start_capture got A_q=%h B_q=%h want 40C00000 40000000",
                        u_if.A_q, u_if.B_q);
            end
         end
         if (u_if.done) begin
            dones++;
            if (first < 0) first = n;
         end
      end
      n_tests++;
      if (dones !== 1 || first !== 28) begin
         n_fail++;
         $display("FAIL busy_single_done got dones=%0d first=%0d want 1 at 28", dones, first);
      end
      n_tests++;
      if (u_if.temp_result !== 32'h40400000) begin
         n_fail++;
         $display("FAIL busy_result got %h want 40400000", u_if.temp_result);
      end
      // start raised in the done cycle is taken on the following edge
      start_op(32'h3F800000, 32'h3FC00000);
      n_tests++;
      if (u_if.busy !== 1'b1 || u_if.done !== 1'b0 || u_if.A_q !== 32'h3F800000) begin
         n_fail++;
         $display("FAIL b2b_accept got busy=%b done=%b A_q=%h want 1 0 3F800000",
                  u_if.busy, u_if.done, u_if.A_q);
      end
      wait_done(lat);
      n_tests++;
      if (lat !== 28 || u_if.temp_result !== 32'h3F2AAAAB) begin
         n_fail++;
         $display("FAIL b2b_result got res=%h lat=%0d want 3F2AAAAB lat=28", u_if.temp_result, lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int dones;
      int lat;
      dones = 0;
      start_op(32'h3F800000, 32'h40400000);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.temp_result !== 32'd0 || u_if.A_q !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_clear got busy=%b done=%b res=%h A_q=%h want 0 0 0 0",
                  u_if.busy, u_if.done, u_if.temp_result, u_if.A_q);
      end
      for (int n = 0; n < 35; n++) begin
         @(posedge clk);
         #1;
         if (n == 2) rst_n = 1'b1;
         if (u_if.done) dones++;
      end
      n_tests++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done got %0d done pulses want 0", dones);
      end
      start_op(32'h40C00000, 32'h40000000);
      wait_done(lat);
      n_tests++;
      if (lat !== 28 || u_if.temp_result !== 32'h40400000) begin
         n_fail++;
         $display("FAIL rst_mid_restart got res=%h lat=%0d want 40400000 lat=28", u_if.temp_result, lat);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      @(posedge clk);
      #1;
      test_basic();
      test_vectors();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
